// File: rtl/char_plane_writer_if.sv
// Text-source / plane-write bundle for char_plane_writer.
// The slave side is the controller; the master side is the text source and plane observer.
interface char_plane_writer_if #(
  parameter int unsigned ROW_BIT_LEN    = 4,
  parameter int unsigned COL_BIT_LEN    = 6,
  parameter int unsigned CHAR_ID_LENGTH = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [CHAR_ID_LENGTH-1:0] in_char;
  logic                      clear_req;
  logic                      busy;
  logic [ROW_BIT_LEN-1:0]    cursor_row;
  logic [COL_BIT_LEN-1:0]    cursor_col;
  logic                      wr_en;
  logic [ROW_BIT_LEN-1:0]    wr_row;
  logic [COL_BIT_LEN-1:0]    wr_col;
  logic [CHAR_ID_LENGTH-1:0] wr_data;

  modport master (
    output in_valid, in_char, clear_req,
    input  in_ready, busy, cursor_row, cursor_col, wr_en, wr_row, wr_col, wr_data
  );

  modport slave (
    input  in_valid, in_char, clear_req,
    output in_ready, busy, cursor_row, cursor_col, wr_en, wr_row, wr_col, wr_data
  );
endinterface

// File: rtl/char_plane_writer.sv
// Terminal-style cursor/write controller for the character plane: accepts character IDs,
// handles CR/LF/BS/FF, and sweeps line and whole-screen clears one cell per cycle.
module char_plane_writer #(
  parameter int unsigned ROW_NUMBER     = 15,
  parameter int unsigned COL_NUMBER     = 40,
  parameter int unsigned ROW_BIT_LEN    = 4,
  parameter int unsigned COL_BIT_LEN    = 6,
  parameter int unsigned CHAR_ID_LENGTH = 8,
  parameter logic [CHAR_ID_LENGTH-1:0] BLANK_ID = 8'h00,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic               clock,
  input  logic               reset_n,
  char_plane_writer_if.slave bus
);

  localparam logic [ROW_BIT_LEN-1:0]    ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0]    COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [CHAR_ID_LENGTH-1:0] CODE_BS  = CHAR_ID_LENGTH'(8'h08);
  localparam logic [CHAR_ID_LENGTH-1:0] CODE_LF  = CHAR_ID_LENGTH'(8'h0A);
  localparam logic [CHAR_ID_LENGTH-1:0] CODE_FF  = CHAR_ID_LENGTH'(8'h0C);
  localparam logic [CHAR_ID_LENGTH-1:0] CODE_CR  = CHAR_ID_LENGTH'(8'h0D);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLEAR_LINE = 2'd1,
    ST_CLEAR_ALL  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [ROW_BIT_LEN-1:0]    cur_row_q, cur_row_d;
  logic [COL_BIT_LEN-1:0]    cur_col_q, cur_col_d;
  logic [ROW_BIT_LEN-1:0]    sw_row_q, sw_row_d;
  logic [COL_BIT_LEN-1:0]    sw_col_q, sw_col_d;
  logic                      wr_en_q, wr_en_d;
  logic [ROW_BIT_LEN-1:0]    wr_row_q, wr_row_d;
  logic [COL_BIT_LEN-1:0]    wr_col_q, wr_col_d;
  logic [CHAR_ID_LENGTH-1:0] wr_data_q, wr_data_d;
  logic                      busy_q, busy_d;

  logic                      ready_c;
  logic                      handshake_c;
  logic                      start_all_c;
  logic [ROW_BIT_LEN-1:0]    row_next_c;

  // Ready depends on the live clear request so a simultaneous char is never taken.
  assign ready_c     = (state_q == ST_IDLE) && !bus.clear_req;
  assign handshake_c = bus.in_valid && ready_c;
  assign start_all_c = bus.clear_req || (handshake_c && (bus.in_char == CODE_FF));
  assign row_next_c  = (cur_row_q == ROW_LAST) ? '0 : cur_row_q + ROW_BIT_LEN'(1);

  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    sw_row_d  = sw_row_q;
    sw_col_d  = sw_col_q;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    // busy trails the state by one cycle so it frames the clear writes exactly
    busy_d    = (state_q != ST_IDLE);

    if (start_all_c) begin
      state_d   = ST_CLEAR_ALL;
      cur_row_d = '0;
      cur_col_d = '0;
      sw_row_d  = '0;
      sw_col_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (handshake_c) begin
            if (bus.in_char == CODE_CR) begin
              cur_col_d = '0;
            end else if (bus.in_char == CODE_LF) begin
              cur_col_d = '0;
              cur_row_d = row_next_c;
              sw_col_d  = '0;
              state_d   = ST_CLEAR_LINE;
            end else if (bus.in_char == CODE_BS) begin
              if (cur_col_q != '0) begin
                cur_col_d = cur_col_q - COL_BIT_LEN'(1);
                wr_en_d   = 1'b1;
                wr_row_d  = cur_row_q;
                wr_col_d  = cur_col_q - COL_BIT_LEN'(1);
                wr_data_d = BLANK_ID;
              end else if (cur_row_q != '0) begin
                cur_row_d = cur_row_q - ROW_BIT_LEN'(1);
                cur_col_d = COL_LAST;
                wr_en_d   = 1'b1;
                wr_row_d  = cur_row_q - ROW_BIT_LEN'(1);
                wr_col_d  = COL_LAST;
                wr_data_d = BLANK_ID;
              end
            end else begin
              wr_en_d   = 1'b1;
              wr_row_d  = cur_row_q;
              wr_col_d  = cur_col_q;
              wr_data_d = bus.in_char;
              if (cur_col_q == COL_LAST) begin
                cur_col_d = '0;
                cur_row_d = row_next_c;
                sw_col_d  = '0;
                state_d   = ST_CLEAR_LINE;
              end else begin
                cur_col_d = cur_col_q + COL_BIT_LEN'(1);
              end
            end
          end
        end

        ST_CLEAR_LINE: begin
          wr_en_d   = 1'b1;
          wr_row_d  = cur_row_q;
          wr_col_d  = sw_col_q;
          wr_data_d = BLANK_ID;
          if (sw_col_q == COL_LAST) begin
            sw_col_d = '0;
            state_d  = ST_IDLE;
          end else begin
            sw_col_d = sw_col_q + COL_BIT_LEN'(1);
          end
        end

        ST_CLEAR_ALL: begin
          wr_en_d   = 1'b1;
          wr_row_d  = sw_row_q;
          wr_col_d  = sw_col_q;
          wr_data_d = BLANK_ID;
          // row/col counters walk the screen in row-major order without a multiply
          if (sw_col_q == COL_LAST) begin
            sw_col_d = '0;
            if (sw_row_q == ROW_LAST) begin
              sw_row_d = '0;
              state_d  = ST_IDLE;
            end else begin
              sw_row_d = sw_row_q + ROW_BIT_LEN'(1);
            end
          end else begin
            sw_col_d = sw_col_q + COL_BIT_LEN'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR_ALL : ST_IDLE;
      cur_row_q <= '0;
      cur_col_q <= '0;
      sw_row_q  <= '0;
      sw_col_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      sw_row_q  <= sw_row_d;
      sw_col_q  <= sw_col_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.in_ready   = ready_c;
  assign bus.busy       = busy_q;
  assign bus.cursor_row = cur_row_q;
  assign bus.cursor_col = cur_col_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_row     = wr_row_q;
  assign bus.wr_col     = wr_col_q;
  assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_char_plane_writer.sv
// Bench for char_plane_writer: a terminal model predicts the per-cycle write stream,
// cursor and ready/busy behaviour for directed and randomized character streams.
module tb_char_plane_writer;

  localparam int ROWS = 15;
  localparam int COLS = 40;
  localparam logic [7:0] BLANK = 8'h00;

  typedef struct packed {
    logic       en;
    logic [3:0] row;
    logic [5:0] col;
    logic [7:0] data;
    logic       rdy;
    logic       busy;
    logic       clr;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int tests_run    = 0;
  int tests_failed = 0;
  int m_row = 0;
  int m_col = 0;
  ent_t exp_q[$];
  ent_t cap_q[$];

  char_plane_writer_if bus ();

  char_plane_writer dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic ent_t mk(logic en, int r, int c, logic [7:0] d, logic clr);
    ent_t e = '0;
    e.en   = en;
    e.row  = 4'(r);
    e.col  = 6'(c);
    e.data = d;
    e.clr  = clr;
    e.busy = clr;
    return e;
  endfunction

  function automatic void push_none();
    exp_q.push_back(mk(1'b0, 0, 0, 8'h00, 1'b0));
  endfunction

  function automatic void push_line(int r);
    for (int c = 0; c < COLS; c++) exp_q.push_back(mk(1'b1, r, c, BLANK, 1'b1));
  endfunction

  function automatic void push_all();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_q.push_back(mk(1'b1, r, c, BLANK, 1'b1));
  endfunction

  // The controller is ready again exactly in the cycle that shows its last write.
  function automatic void seal();
    exp_q[exp_q.size()-1].rdy = 1'b1;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    push_none();
    push_all();
    m_row = 0;
    m_col = 0;
    seal();
  endfunction

  function automatic void model_char(logic [7:0] c);
    exp_q.delete();
    case (c)
      8'h0D: begin push_none(); m_col = 0; end
      8'h0A: begin
        push_none();
        m_col = 0;
        m_row = (m_row + 1) % ROWS;
        push_line(m_row);
      end
      8'h08: begin
        if (m_col > 0) begin
          m_col = m_col - 1;
          exp_q.push_back(mk(1'b1, m_row, m_col, BLANK, 1'b0));
        end else if (m_row > 0) begin
          m_row = m_row - 1;
          m_col = COLS - 1;
          exp_q.push_back(mk(1'b1, m_row, m_col, BLANK, 1'b0));
        end else begin
          push_none();
        end
      end
      8'h0C: begin push_none(); push_all(); m_row = 0; m_col = 0; end
      default: begin
        exp_q.push_back(mk(1'b1, m_row, m_col, c, 1'b0));
        if (m_col == COLS - 1) begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
          push_line(m_row);
        end else begin
          m_col = m_col + 1;
        end
      end
    endcase
    seal();
  endfunction

  function automatic bit entry_differs(int i);
    ent_t a = cap_q[i];
    ent_t e = exp_q[i];
    if (a.en !== e.en) return 1'b1;
    if (e.en && (a.row !== e.row || a.col !== e.col || a.data !== e.data)) return 1'b1;
    if (a.rdy !== e.rdy) return 1'b1;
    if (e.clr && a.busy !== 1'b1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic string ent_str(ent_t x);
    return $sformatf("en=%0b (%0d,%0d)=%02h rdy=%0b busy=%0b", x.en, x.row, x.col, x.data, x.rdy, x.busy);
  endfunction

  function automatic ent_t sample();
    ent_t s = '0;
    s.en   = bus.wr_en;
    s.row  = bus.wr_row;
    s.col  = bus.wr_col;
    s.data = bus.wr_data;
    s.rdy  = bus.in_ready;
    s.busy = bus.busy;
    return s;
  endfunction

  // ---------------- stimulus / capture ----------------
  task automatic capture(input int n);
    cap_q.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_q.push_back(sample());
    end
  endtask

  task automatic send_capture(input logic [7:0] c, input int n);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    while (bus.in_ready !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL handshake_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, waited);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    capture(n);
  endtask

  task automatic step(input logic [7:0] c);
    model_char(c);
    send_capture(c, exp_q.size());
  endtask

  task automatic clear_pulse_capture(input int n);
    @(negedge clk);
    bus.clear_req = 1'b1;
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
    capture(n);
  endtask

  task automatic goto_cell(input int r, input int c);
    step(8'h0C);
    for (int i = 0; i < r; i++) step(8'h0A);
    for (int i = 0; i < c; i++) step(8'h78);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_char = 8'h00; bus.clear_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.wr_en, bus.busy, bus.in_ready, bus.cursor_row, bus.cursor_col,
         bus.wr_row, bus.wr_col, bus.wr_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%b busy=%b rdy=%b cur=(%0d,%0d) wr=(%0d,%0d)=%02h, want all 0",
               bus.wr_en, bus.busy, bus.in_ready, bus.cursor_row, bus.cursor_col, bus.wr_row, bus.wr_col, bus.wr_data);
    end
    rst_n = 1'b1;
    exp_q.delete(); push_all(); seal();
    m_row = 0; m_col = 0;
    capture(600);
    for (int i = 0; i < cap_q.size(); i++) begin
      tests_run++;
      if (entry_differs(i)) begin
        tests_failed++;
        $display("FAIL reset_sweep[%0d]: got %s, want %s", i, ent_str(cap_q[i]), ent_str(exp_q[i]));
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.cursor_row !== 4'd0 || bus.cursor_col !== 6'd0) begin
      tests_failed++;
      $display("FAIL reset_done: got busy=%b wr_en=%b rdy=%b cur=(%0d,%0d), want 0 0 1 (0,0)",
               bus.busy, bus.wr_en, bus.in_ready, bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_reset_mid_clear();
    clear_pulse_capture(101);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got wr_en=%b busy=%b, want 0 0", bus.wr_en, bus.busy);
    end
    rst_n = 1'b1;
    exp_q.delete(); push_all(); seal();
    m_row = 0; m_col = 0;
    capture(600);
    for (int i = 0; i < cap_q.size(); i++) begin
      tests_run++;
      if (entry_differs(i)) begin
        tests_failed++;
        $display("FAIL reset_restart[%0d]: got %s, want %s", i, ent_str(cap_q[i]), ent_str(exp_q[i]));
      end
    end
  endtask

  task automatic test_basic_chars();
    logic [7:0] chars [2];
    chars[0] = 8'h41;
    chars[1] = 8'h42;
    for (int k = 0; k < 2; k++) begin
      step(chars[k]);
      for (int i = 0; i < cap_q.size(); i++) begin
        tests_run++;
        if (entry_differs(i)) begin
          tests_failed++;
          $display("FAIL basic_char%0d[%0d]: got %s, want %s", k, i, ent_str(cap_q[i]), ent_str(exp_q[i]));
        end
      end
    end
    tests_run++;
    if (bus.cursor_row !== 4'd0 || bus.cursor_col !== 6'd2) begin
      tests_failed++;
      $display("FAIL basic_cursor: got (%0d,%0d), want (0,2)", bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_line_wrap();
    goto_cell(3, 39);
    step(8'h55);
    for (int i = 0; i < cap_q.size(); i++) begin
      tests_run++;
      if (entry_differs(i)) begin
        tests_failed++;
        $display("FAIL line_wrap[%0d]: got %s, want %s", i, ent_str(cap_q[i]), ent_str(exp_q[i]));
      end
    end
    tests_run++;
    if (bus.cursor_row !== 4'd4 || bus.cursor_col !== 6'd0) begin
      tests_failed++;
      $display("FAIL line_wrap_cursor: got (%0d,%0d), want (4,0)", bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_row_wrap();
    goto_cell(14, 5);
    step(8'h0A);
    for (int i = 0; i < cap_q.size(); i++) begin
      tests_run++;
      if (entry_differs(i)) begin
        tests_failed++;
        $display("FAIL row_wrap[%0d]: got %s, want %s", i, ent_str(cap_q[i]), ent_str(exp_q[i]));
      end
    end
    tests_run++;
    if (bus.cursor_row !== 4'd0 || bus.cursor_col !== 6'd0) begin
      tests_failed++;
      $display("FAIL row_wrap_cursor: got (%0d,%0d), want (0,0)", bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_backspace();
    goto_cell(2, 0);
    step(8'h08);
    for (int i = 0; i < cap_q.size(); i++) begin
      tests_run++;
      if (entry_differs(i)) begin
        tests_failed++;
        $display("FAIL bs_row_up[%0d]: got %s, want %s", i, ent_str(cap_q[i]), ent_str(exp_q[i]));
      end
    end
    tests_run++;
    if (bus.cursor_row !== 4'd1 || bus.cursor_col !== 6'd39) begin
      tests_failed++;
      $display("FAIL bs_row_up_cursor: got (%0d,%0d), want (1,39)", bus.cursor_row, bus.cursor_col);
    end
    step(8'h0C);
    step(8'h08);
    for (int i = 0; i < cap_q.size(); i++) begin
      tests_run++;
      if (entry_differs(i)) begin
        tests_failed++;
        $display("FAIL bs_origin[%0d]: got %s, want %s", i, ent_str(cap_q[i]), ent_str(exp_q[i]));
      end
    end
    tests_run++;
    if (bus.cursor_row !== 4'd0 || bus.cursor_col !== 6'd0) begin
      tests_failed++;
      $display("FAIL bs_origin_cursor: got (%0d,%0d), want (0,0)", bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_clear_priority();
    // abort a line clear part way through
    goto_cell(5, 10);
    model_char(8'h0A);
    send_capture(8'h0A, 11);
    model_clear();
    clear_pulse_capture(601);
    for (int i = 0; i < cap_q.size(); i++) begin
      tests_run++;
      if (entry_differs(i)) begin
        tests_failed++;
        $display("FAIL abort_line[%0d]: got %s, want %s", i, ent_str(cap_q[i]), ent_str(exp_q[i]));
      end
    end
    // restart a sweep near cell 300
    model_clear();
    clear_pulse_capture(301);
    for (int i = 0; i < cap_q.size(); i++) begin
      tests_run++;
      if (entry_differs(i)) begin
        tests_failed++;
        $display("FAIL sweep_head[%0d]: got %s, want %s", i, ent_str(cap_q[i]), ent_str(exp_q[i]));
      end
    end
    model_clear();
    clear_pulse_capture(601);
    for (int i = 0; i < cap_q.size(); i++) begin
      tests_run++;
      if (entry_differs(i)) begin
        tests_failed++;
        $display("FAIL sweep_restart[%0d]: got %s, want %s", i, ent_str(cap_q[i]), ent_str(exp_q[i]));
      end
    end
    // valid and clear in the same idle cycle
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h5A;
    bus.clear_req = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_with_clear_ready: got %b, want 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
    bus.in_valid  = 1'b0;
    model_clear();
    capture(601);
    for (int i = 0; i < cap_q.size(); i++) begin
      tests_run++;
      if (entry_differs(i)) begin
        tests_failed++;
        $display("FAIL valid_with_clear[%0d]: got %s, want %s", i, ent_str(cap_q[i]), ent_str(exp_q[i]));
      end
    end
    tests_run++;
    if (bus.cursor_row !== 4'd0 || bus.cursor_col !== 6'd0) begin
      tests_failed++;
      $display("FAIL valid_with_clear_cursor: got (%0d,%0d), want (0,0)", bus.cursor_row, bus.cursor_col);
    end
  endtask

  task automatic test_random_stream();
    for (int n = 0; n < 120; n++) begin
      int unsigned r;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      if (r < 10)      c = 8'h0D;
      else if (r < 20) c = 8'h0A;
      else if (r < 34) c = 8'h08;
      else if (r < 36) c = 8'h0C;
      else             c = 8'($urandom_range(16, 255));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      step(c);
      for (int i = 0; i < cap_q.size(); i++) begin
        tests_run++;
        if (entry_differs(i)) begin
          tests_failed++;
          $display("FAIL random%0d_char%02h[%0d]: got %s, want %s", n, c, i, ent_str(cap_q[i]), ent_str(exp_q[i]));
        end
      end
      tests_run++;
      if (bus.cursor_row !== 4'(m_row) || bus.cursor_col !== 6'(m_col)) begin
        tests_failed++;
        $display("FAIL random%0d_cursor: got (%0d,%0d), want (%0d,%0d)", n, bus.cursor_row, bus.cursor_col, m_row, m_col);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_chars();
    test_line_wrap();
    test_row_wrap();
    test_backspace();
    test_clear_priority();
    test_reset_mid_clear();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
